// File: rtl/seg7_scan_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants for the multiplexed seven-segment driver:
//               hex glyph table, blank pattern and segment bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Segment bit positions inside the 8-bit {dp,g,f,e,d,c,b,a} bus
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // All segments dark, expressed active-high (polarity is applied at the pins)
    localparam logic [7:0] SEG_OFF = 8'h00;

    // Active-high glyphs {g,f,e,d,c,b,a} for 0..F
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage
`default_nettype wire

// File: rtl/seg7_scan_display_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_display_if
// Description : Host-side controls and display pins of the scanned driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    enable;
    logic                    blank_lz;
    logic                    blink_en;
    logic [7:0]              seg_out;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    scan_tick;

    modport master (
        output load, data_in, dp_in, enable, blank_lz, blink_en,
        input  seg_out, digit_sel, scan_tick
    );

    modport slave (
        input  load, data_in, dp_in, enable, blank_lz, blink_en,
        output seg_out, digit_sel, scan_tick
    );
endinterface
`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decoder
// Description : Combinational hex nibble to active-high seven-segment glyph.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Straight table lookup of the glyph
    always_comb begin
        seg_o = SEG_HEX[nibble_i];
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_display
// Description : Time-multiplexed NUM_DIGITS hex display scanner with shadow
//               load, leading-zero blanking, decimal points, blink and
//               selectable pin polarity.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 64,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                clk,
    input  logic                reset,
    seg7_scan_display_if.slave  scan_if
);

    localparam int PS_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BL_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_DIV - 1);

    // XOR masks that turn active-high patterns into pin levels
    localparam logic                  POL      = (ACTIVE_LOW != 0);
    localparam logic [7:0]            SEG_MASK = {8{POL}};
    localparam logic [NUM_DIGITS-1:0] SEL_MASK = {NUM_DIGITS{POL}};

    logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q,   shadow_dp_d;
    logic [PS_W-1:0]         prescaler_q,   prescaler_d;
    logic [IDX_W-1:0]        digit_idx_q,   digit_idx_d;
    logic [BL_W-1:0]         blink_cnt_q,   blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic                    scan_tick_q,   scan_tick_d;
    // Raw (active-high, ungated) pattern of the digit in the current slot
    logic [7:0]              seg_raw_q,     seg_raw_d;
    logic [NUM_DIGITS-1:0]   sel_raw_q,     sel_raw_d;
    // Pin-level registers after enable/blink gating and polarity
    logic [7:0]              seg_out_q,     seg_out_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q,   digit_sel_d;

    logic                    tick;
    logic [IDX_W-1:0]        digit_next;
    logic [3:0]              sel_nibble;
    logic                    sel_dp;
    logic                    nonzero_above;
    logic                    blanked;
    logic [NUM_DIGITS-1:0]   sel_onehot;
    logic [6:0]              hex_seg;
    logic                    visible;

    seg7_hex_decoder u_hex_decoder (
        .nibble_i (sel_nibble),
        .seg_o    (hex_seg)
    );

    // Slot timing, digit selection from the shadow value and blanking test
    always_comb begin
        tick          = (prescaler_q == PS_LAST);
        digit_next    = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IDX_W'(1);
        sel_nibble    = 4'h0;
        sel_dp        = 1'b0;
        nonzero_above = 1'b0;
        sel_onehot    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IDX_W'(k) == digit_next) begin
                sel_nibble    = shadow_data_q[4*k +: 4];
                sel_dp        = shadow_dp_q[k];
                sel_onehot[k] = 1'b1;
            end
            if ((IDX_W'(k) >= digit_next) && (shadow_data_q[4*k +: 4] != 4'h0)) begin
                nonzero_above = 1'b1;
            end
        end
        // Digit 0 always shows, so an all-zero value still reads "0"
        blanked = scan_if.blank_lz && (digit_next != '0) && !nonzero_above;
    end

    // Next-state for counters, shadow registers and the gated output pins
    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        if (scan_if.load) begin
            shadow_data_d = scan_if.data_in;
            shadow_dp_d   = scan_if.dp_in;
        end

        prescaler_d = tick ? '0 : prescaler_q + PS_W'(1);
        digit_idx_d = tick ? digit_next : digit_idx_q;
        scan_tick_d = tick;

        // Blink counter advances once per complete scan round
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (tick && (digit_idx_q == IDX_LAST)) begin
            if (blink_cnt_q == BL_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BL_W'(1);
            end
        end

        seg_raw_d = seg_raw_q;
        sel_raw_d = sel_raw_q;
        if (tick) begin
            seg_raw_d = {sel_dp, blanked ? 7'h00 : hex_seg};
            sel_raw_d = sel_onehot;
        end

        // Gating follows the post-edge blink phase so it switches with the digit
        visible     = scan_if.enable && (!scan_if.blink_en || blink_phase_d);
        seg_out_d   = (visible ? seg_raw_d : SEG_OFF) ^ SEG_MASK;
        digit_sel_d = (visible ? sel_raw_d : '0) ^ SEL_MASK;
    end

    // State registers with asynchronous clear to the dark display
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            prescaler_q   <= '0;
            digit_idx_q   <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            scan_tick_q   <= 1'b0;
            seg_raw_q     <= SEG_OFF;
            sel_raw_q     <= '0;
            seg_out_q     <= SEG_OFF ^ SEG_MASK;
            digit_sel_q   <= SEL_MASK;
        end else begin
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            prescaler_q   <= prescaler_d;
            digit_idx_q   <= digit_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            scan_tick_q   <= scan_tick_d;
            seg_raw_q     <= seg_raw_d;
            sel_raw_q     <= sel_raw_d;
            seg_out_q     <= seg_out_d;
            digit_sel_q   <= digit_sel_d;
        end
    end

    assign scan_if.seg_out   = seg_out_q;
    assign scan_if.digit_sel = digit_sel_q;
    assign scan_if.scan_tick = scan_tick_q;

endmodule
`default_nettype wire

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised multi-digit seven-segment driver for the MiniSRC board I/O. It generalises the fixed two-digit upper/lower display outputs into one time-multiplexed scanner of NUM_DIGITS hex digits.
- Latches a value from the OutPort path on a load strobe and scans it out one digit at a time.
- Adds leading-zero blanking, per-digit decimal points, blink mode and selectable segment polarity.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000: clk cycles per digit slot; must be >= 2.
- BLINK_DIV, 64: full scan rounds per blink half-period; must be >= 1.
- ACTIVE_LOW, 1: 1 drives seg_out and digit_sel active-low (DE0 board); 0 drives them active-high.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  captures data_in and dp_in into the shadow registers.
- data_in  in  4*NUM_DIGITS  hex value; nibble k is shown on digit k (digit 0 = least significant).
- dp_in  in  NUM_DIGITS  decimal-point request per digit.
- enable  in  1  0 forces all outputs to the off level.
- blank_lz  in  1  enables leading-zero blanking.
- blink_en  in  1  enables blinking of the whole display.
- seg_out  out  8  segment lines {dp,g,f,e,d,c,b,a}.
- digit_sel  out  NUM_DIGITS  one-hot digit strobe.
- scan_tick  out  1  one-cycle pulse at each digit-slot boundary.

Behaviour:
- Reset (asynchronous, active-high): all state clears.
  - shadow_data = 0, shadow_dp = 0, prescaler = 0, digit_idx = 0, blink_cnt = 0, blink_phase = 1 (visible), scan_tick = 0.
  - seg_out and digit_sel go to the off level: all 1s when ACTIVE_LOW=1, all 0s when ACTIVE_LOW=0.
- Reset asserted mid-scan returns these values immediately. Scanning resumes from digit 0 after release.
- Load: on a rising edge with load=1, the shadow registers take data_in and dp_in. Outputs are unaffected until the next slot.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick is asserted when prescaler == REFRESH_DIV-1.
  - scan_tick is the registered copy of tick.
- Digit index: on tick, digit_idx advances by one and wraps from NUM_DIGITS-1 to 0. With NUM_DIGITS=1 it stays at 0.
- Output update on tick (registered; visible the cycle after the tick):
  - Shown digit n is the new digit_idx value.
  - digit_sel becomes one-hot at bit n.
  - seg_out becomes decode(nibble n) with dp = shadow_dp[n], or all segments off if the digit is blanked.
  - Polarity is applied last.
- Outputs hold between ticks.
- Simultaneous load and tick: the output register samples the pre-edge shadow value. The new value first appears at the following tick.
- Leading-zero blanking (blank_lz=1): digit n is blanked when every nibble k >= n of shadow_data is zero. Digit 0 is never blanked, so the value 0 displays "0". The dp bit is still shown on a blanked digit.
- Blink:
  - blink_cnt increments when tick fires with digit_idx == NUM_DIGITS-1 (end of a scan round).
  - At BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
  - While blink_en=1 and blink_phase=0, seg_out and digit_sel are off.
  - blink_en=0 forces visibility but the counters keep running.
- enable=0: seg_out and digit_sel are off from the next edge. Prescaler, digit index and blink counters keep running. Loads are still accepted.
- Hex decode, active-high: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71; dp is bit 7.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex segment constant table;
  - SEG_OFF;
  - the bit-position constants for dp, g, f, e, d, c, b, a.
- Sub-module seg7_hex_decoder: combinational, 4-bit nibble in, 7 segments out (active-high). Instantiated once on the selected nibble.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=2, ACTIVE_LOW=1, enable=1 unless stated.
1. Reset release, then load data_in=16'h12AF, dp_in=0 → digit_sel cycles E,D,B,7 at one slot per 4 clk. seg_out sequence is the one's complement of 71,77,5B,06 with bit 7 = 1.
2. Load 16'h0005 with blank_lz=1 → digits 1–3 output FF; digit 0 outputs 92. With blank_lz=0, digits 1–3 output C0.
3. Load 16'h0000 with blank_lz=1, dp_in=4'b0100 → digit 0 shows C0. Digit 2 shows 7F (dp only). Digits 1 and 3 show FF.
4. Assert load with 16'h8888 on the exact tick cycle → that slot shows the old value. The next slot shows 80.
5. blink_en=1 → outputs visible for 2 scan rounds (32 clk), then all off (seg FF, digit_sel F) for 32 clk, repeating. enable=0 mid-scan → off next cycle; re-enabling resumes at the correct running digit_idx.
6. Assert reset asynchronously between clock edges mid-scan → seg_out=FF and digit_sel=F immediately. After release, the first digit shown is digit 1 following the first tick, and the shadow value is 0.
